// File: rtl/inv_sub_bytes_engine.sv
// ============================================================================
// inv_sub_bytes_engine
//
// AES InvSubBytes engine for the decrypt datapath. A 128-bit state is
// accepted on a valid/ready handshake and latched into a work register. The
// engine then pushes BYTES_PER_CYCLE bytes per beat through the S-box ROM
// lanes. Each lane has a one-cycle registered read. The looked-up bytes are
// assembled into out_state, which is presented until the consumer takes it.
//
// FSM: IDLE -> RUN (BEATS cycles) -> FLUSH (1 cycle) -> DONE -> IDLE
// Latency: if the handshake is accepted in cycle t, out_valid is high in
// cycle t + BEATS + 2.
//
// Parameters
//   BYTES_PER_CYCLE  number of ROM lanes (1, 2, 4, 8 or 16); BEATS = 16/BYTES_PER_CYCLE
//
// Ports
//   clk        in   1    clock, rising edge
//   rst        in   1    asynchronous active-high reset
//   in_valid   in   1    in_state is valid
//   in_ready   out  1    engine can accept a block (IDLE and not in reset)
//   in_state   in   128  input state; byte i = in_state[127-8i -: 8]
//   inv        in   1    only with SUB_BYTES_FWD_EN: 1 = inverse S-box, 0 = forward S-box
//   out_valid  out  1    out_state holds a finished block
//   out_ready  in   1    consumer accepts out_state
//   out_state  out  128  S-box applied to every byte, same byte order as in_state
//   busy       out  1    high in RUN and FLUSH
//
// Configuration macro
//   SUB_BYTES_FWD_EN  when defined, adds the `inv` port and a forward S-box
//                     table so that encryption and decryption can share the
//                     engine. When undefined, only the inverse table exists.
// ============================================================================
module inv_sub_bytes_engine #(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef SUB_BYTES_FWD_EN
    input  logic         inv,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int BEATS  = 16 / BYTES_PER_CYCLE;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    // ------------------------------------------------------------------
    // S-box tables
    // ------------------------------------------------------------------
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

`ifdef SUB_BYTES_FWD_EN
    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };
`endif

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [127:0]        work_q, work_d;
`ifdef SUB_BYTES_FWD_EN
    logic                inv_q, inv_d;
`endif

    // Control decoded by the FSM.
    logic                load;      // accept handshake this cycle
    logic                rom_en;    // ROM lanes read this cycle
    logic                wr_en;     // rom_data is written to out_state this cycle
    logic [BEAT_W-1:0]   wr_beat;   // beat slot that rom_data belongs to

    logic [7:0]                    work_bytes [16];
    logic [8*BYTES_PER_CYCLE-1:0]  rom_data;   // lane j at rom_data[8j +: 8]

    // ------------------------------------------------------------------
    // FSM: next state and control
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        load    = 1'b0;
        rom_en  = 1'b0;
        wr_en   = 1'b0;
        wr_beat = '0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    beat_d  = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                rom_en = 1'b1;
                // ROM data read during the previous RUN cycle lands now. It
                // belongs to the previous beat. At beat 0 nothing is pending.
                if (beat_q != '0) begin
                    wr_en   = 1'b1;
                    wr_beat = beat_q - 1'b1;
                end
                if (beat_q == BEAT_W'(BEATS - 1)) begin
                    beat_d  = '0;
                    state_d = S_FLUSH;
                end else begin
                    beat_d  = beat_q + 1'b1;
                end
            end

            S_FLUSH: begin
                // Drain the last beat's read. The ROM enables stay low.
                wr_en   = 1'b1;
                wr_beat = BEAT_W'(BEATS - 1);
                state_d = S_DONE;
            end

            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The input state (and selector) is captured only on the accept edge.
    always_comb begin
        work_d = work_q;
        if (load) begin
            work_d = in_state;
        end
    end

`ifdef SUB_BYTES_FWD_EN
    always_comb begin
        inv_d = inv_q;
        if (load) begin
            inv_d = inv;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            work_q  <= work_d;
        end
    end

`ifdef SUB_BYTES_FWD_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inv_q <= 1'b1;
        end else begin
            inv_q <= inv_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Work register byte view (byte 0 is the most significant byte)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_work_bytes
        assign work_bytes[gi] = work_q[127 - 8*gi -: 8];
    end

    // ------------------------------------------------------------------
    // ROM lanes: lane j reads byte (beat*BYTES_PER_CYCLE + j)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_lane
        logic [3:0] byte_idx;
        logic [7:0] rom_addr;
        logic [7:0] rom_q, rom_d;

        assign byte_idx = 4'(int'(beat_q) * BYTES_PER_CYCLE + gi);
        assign rom_addr = work_bytes[byte_idx];

        always_comb begin
            rom_d = rom_q;
            if (rom_en) begin
`ifdef SUB_BYTES_FWD_EN
                rom_d = inv_q ? INV_SBOX[rom_addr] : FWD_SBOX[rom_addr];
`else
                rom_d = INV_SBOX[rom_addr];
`endif
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rom_q <= '0;
            end else begin
                rom_q <= rom_d;
            end
        end

        assign rom_data[8*gi +: 8] = rom_q;
    end

    // ------------------------------------------------------------------
    // Output assembly: byte k lives in beat slot k/BYTES_PER_CYCLE and is
    // produced by lane k%BYTES_PER_CYCLE. Each byte is written only when
    // its slot is drained, so it is stable in DONE.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 16; gi++) begin : g_out_bytes
        localparam int SLOT = gi / BYTES_PER_CYCLE;
        localparam int LANE = gi % BYTES_PER_CYCLE;

        logic [7:0] out_byte_q, out_byte_d;

        always_comb begin
            out_byte_d = out_byte_q;
            if (wr_en && (wr_beat == BEAT_W'(SLOT))) begin
                out_byte_d = rom_data[8*LANE +: 8];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_byte_q <= '0;
            end else begin
                out_byte_q <= out_byte_d;
            end
        end

        assign out_state[127 - 8*gi -: 8] = out_byte_q;
    end

    // ------------------------------------------------------------------
    // Handshake outputs
    // ------------------------------------------------------------------
    // in_ready is also qualified with rst so that it reads low for the whole
    // reset pulse, not only after the state register has settled.
    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) || (state_q == S_FLUSH);

endmodule

// File: tb/tb_inv_sub_bytes_engine.sv
// ============================================================================
// tb_inv_sub_bytes_engine
//
// Self-checking bench for inv_sub_bytes_engine. The reference S-boxes are
// built from GF(2^8) arithmetic: the multiplicative inverse followed by the
// AES affine map. The inverse table is obtained by inverting the forward one.
// Set TB_BPC to exercise other lane counts.
// ============================================================================
module tb_inv_sub_bytes_engine #(
    parameter int TB_BPC = 4
);

    localparam int BEATS = 16 / TB_BPC;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         inv_sel;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    inv_sub_bytes_engine #(
        .BYTES_PER_CYCLE(TB_BPC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef SUB_BYTES_FWD_EN
        .inv       (inv_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inverse(input logic [7:0] a);
        logic [7:0] p;
        p = 8'h01;
        if (a == 8'h00) return 8'h00;
        for (int i = 0; i < 254; i++) p = gmul(p, a);   // a^254 = a^-1
        return p;
    endfunction

    task automatic build_tables();
        logic [7:0]  b;
        logic [15:0] bb;
        for (int a = 0; a < 256; a++) begin
            b  = gf_inverse(8'(a));
            bb = {b, b};
            fwd_tab[a] = b ^ bb[14 -: 8] ^ bb[13 -: 8] ^ bb[12 -: 8] ^ bb[11 -: 8] ^ 8'h63;
        end
        for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);
    endtask

    function automatic logic [127:0] model(input logic [127:0] st, input logic sel);
        logic [127:0] r;
        logic [7:0]   bv;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            bv = st[127 - 8*i -: 8];
            r[127 - 8*i -: 8] = sel ? inv_tab[bv] : fwd_tab[bv];
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Sends one block and returns the result. Starts and ends just after a
    // falling edge. Holds out_ready low for `hold` cycles while toggling the
    // input side, then consumes the result.
    task automatic run_block(input logic [127:0] st, input logic sel, input int hold,
                             output logic [127:0] res);
        int w;
        int n;
        int bad;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("accept_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_state = st;
        inv_sel  = sel;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        inv_sel  = 1'($urandom);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        // Valid in cycle t+BEATS+2, i.e. BEATS+1 edges after the accept edge.
        check("latency", n, BEATS + 1);
        res = out_state;
        check("result", out_state, model(st, sel));
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom);
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (!out_valid || in_ready || out_state !== res) bad++;
        end
        if (hold > 0) check("backpressure", bad, 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("drain", out_valid, 1'b0);
        out_ready = 1'b0;
        $display("blk in=%h inv=%0d out=%h lat=%0d hold=%0d", st, sel, res, n, hold);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    localparam logic [127:0] VEC_IN  = 128'h637C777BF26B6FC53001672BFED7AB76;
    localparam logic [127:0] VEC_OUT = 128'h000102030405060708090A0B0C0D0E0F;

    initial begin
        logic [127:0] res;
        logic [127:0] st;

        build_tables();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        inv_sel   = 1'b1;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_state", out_state, '0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1'b1);

        // Known vector with 10 cycles of backpressure
        run_block(VEC_IN, 1'b1, 10, res);
        check("vector", res, VEC_OUT);

        // Extremes
        run_block({16{8'h00}}, 1'b1, 0, res);
        check("ext_00", res, {16{8'h52}});
        run_block({16{8'hFF}}, 1'b1, 1, res);
        check("ext_ff", res, {16{8'h7D}});
        run_block({16{8'h16}}, 1'b1, 0, res);
        check("ext_16", res, {16{8'hFF}});

        // Mid-run reset at beat 2
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_out_state", out_state, '0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", in_ready, 1'b1);
        run_block(VEC_IN, 1'b1, 2, res);
        check("midrst_vector", res, VEC_OUT);

`ifdef SUB_BYTES_FWD_EN
        // Forward selection through the shared engine
        run_block(VEC_OUT, 1'b0, 0, res);
        check("fwd_vector", res, VEC_IN);
`endif

        // Randomized blocks
        for (int k = 0; k < 12; k++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
`ifdef SUB_BYTES_FWD_EN
            run_block(st, 1'($urandom), $urandom_range(0, 4), res);
`else
            run_block(st, 1'b1, $urandom_range(0, 4), res);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
